piso_tx_arbiter: RTL and testbench
==================================

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of each requester data word, >= 2.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, 2 to 8.
REQ-003 Port clk  input  1  clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-006 Port req_data  input  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port req_ready  output  NUM_REQ  one-hot (or zero) acceptance strobe, combinational.
REQ-008 Port ser_out  output  1  registered serial line, idle high.
REQ-009 Port ser_active  output  1  registered; high while a frame is on ser_out.
REQ-010 Port grant_id  output  clog2(NUM_REQ)  registered index of requester whose frame is in progress.
REQ-011 Port done  output  1  registered one-cycle pulse marking the stop bit of each frame.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-013 Acceptance SHALL occur only in IDLE or STOP, on a cycle where at least one req_valid is high; transfer = req_valid[i] & req_ready[i].
REQ-014 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; the first valid requester wins; exactly one req_ready bit high.
REQ-015 req_ready SHALL be all-zero in START, DATA, PARITY and while rst is high.
REQ-016 On the acceptance edge: winner word captured into internal shift register, grant_id and last_grant updated, state -> START.
REQ-017 START: ser_out=0 for one cycle, first visible the cycle after acceptance.
REQ-018 DATA: DATA_W cycles, MSB first, one bit per cycle via left shift of the captured word.
REQ-019 STOP: ser_out=1 and done=1 for one cycle; next state START if a word is accepted that cycle, else IDLE.
REQ-020 Back-to-back frames SHALL have no idle cycle between STOP and next START.
REQ-021 ser_active SHALL be high from START through STOP inclusive, low in IDLE.
REQ-022 req_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-023 Requesters MAY drop req_valid without acceptance; no penalty, pointer unchanged.
REQ-024 In IDLE ser_out=1, done=0; grant_id holds last value.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, ser_out=1, ser_active=0, done=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 first priority).
REQ-026 Reset mid-frame SHALL abort the frame immediately; no partial resumption after release.
REQ-027 First acceptance possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro PISO_TX_PARITY_EN defined: PARITY state after DATA, ser_out = XOR of the captured word (even parity), frame length DATA_W+3 cycles.
REQ-029 Macro PISO_TX_PARITY_EN undefined: no PARITY state, DATA -> STOP, frame length DATA_W+2 cycles.

Verification (DATA_W=8, NUM_REQ=4)
REQ-030 Reset then req_valid=0001, data0=0xA5 -> ser_out 0,1,0,1,0,0,1,0,1,[0 if EN],1; done high only on stop cycle; grant_id=0.
REQ-031 req_valid=1111 held continuously -> grant order 0,1,2,3,0; START follows each STOP with no idle cycle; ser_active stays high.
REQ-032 After a grant to 2, req_valid=1101 -> next grant 3, then 0, then 2.
REQ-033 rst asserted during data bit 3 -> same cycle ser_out=1, ser_active=0; after release, req0 data 0xFF -> complete frame from START.
REQ-034 req0 data 0x07 with EN -> parity bit 1, frame 11 cycles; without EN -> 10 cycles, no parity bit.
REQ-035 req_data0 changed 0x3C->0xC3 one cycle after acceptance -> frame carries 0x3C.

Source files
------------

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbitrated PISO transmitter: grants one requester word per frame and shifts it out MSB first.
// Optional even parity bit between data and stop is enabled by defining PISO_TX_PARITY_EN.
module piso_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       ser_out,
  output logic                       ser_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cand;
  logic                win_found;
  logic                accept_ok;
  logic                accept;
  logic [DATA_W-1:0]   win_word;
`ifdef PISO_TX_PARITY_EN
  logic                par;
`endif

  // Round-robin search: first valid requester after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k + 1) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    accept_ok = ((state == IDLE) || (state == STOP)) && !rst;
    accept    = accept_ok && win_found;
    req_ready = '0;
    if (accept)
      req_ready[win_id] = 1'b1;
    win_word = req_data[win_id*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ser_out    <= 1'b1;
      ser_active <= 1'b0;
      done       <= 1'b0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      shreg      <= '0;
      cnt        <= '0;
`ifdef PISO_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            shreg      <= win_word;
`ifdef PISO_TX_PARITY_EN
            par        <= ^win_word;
`endif
            grant_id   <= win_id;
            last_grant <= win_id;
            state      <= START;
            ser_out    <= 1'b0;
            ser_active <= 1'b1;
          end else begin
            state      <= IDLE;
            ser_out    <= 1'b1;
            ser_active <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          ser_out <= shreg[DATA_W-1];
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          cnt     <= '0;
        end
        DATA: begin
          // The MSB was already driven on the START->DATA edge, so DATA spans DATA_W cycles.
          if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef PISO_TX_PARITY_EN
            state   <= PARITY;
            ser_out <= par;
`else
            state   <= STOP;
            ser_out <= 1'b1;
            done    <= 1'b1;
`endif
          end else begin
            cnt     <= cnt + 1'b1;
            ser_out <= shreg[DATA_W-1];
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state   <= STOP;
          ser_out <= 1'b1;
          done    <= 1'b1;
        end
`endif
        default: begin
          state      <= IDLE;
          ser_out    <= 1'b1;
          ser_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter (DATA_W=8, NUM_REQ=4); drives on falling edges and checks there.
module tb_piso_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        ser_out;
  logic        ser_active;
  logic [1:0]  grant_id;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  piso_tx_arbiter #(.DATA_W(8), .NUM_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .grant_id   (grant_id),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called on the falling edge where START is visible; returns on the stop-bit falling edge.
  task automatic check_frame(input int id, input logic [7:0] w);
    check("start_ser", ser_out, 0);
    check("start_active", ser_active, 1);
    check("start_grant", grant_id, id);
    check("start_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("data_bit", ser_out, w[7-i]);
      check("data_active", ser_active, 1);
      check("data_done", done, 0);
      check("data_ready", req_ready, 0);
    end
`ifdef PISO_TX_PARITY_EN
    @(negedge clk);
    check("parity_bit", ser_out, ^w);
    check("parity_done", done, 0);
`endif
    @(negedge clk);
    check("stop_ser", ser_out, 1);
    check("stop_done", done, 1);
    check("stop_active", ser_active, 1);
  endtask

  task automatic check_idle(input int id);
    check("idle_ser", ser_out, 1);
    check("idle_active", ser_active, 0);
    check("idle_done", done, 0);
    check("idle_grant", grant_id, id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("rst_ser", ser_out, 1);
    check("rst_active", ser_active, 0);
    check("rst_done", done, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] nxt_ready [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] d [4] = '{8'h11, 8'h3C, 8'h96, 8'hE1};

    // Single frame 0xA5 from requester 0
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1 check("ready_r0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check_frame(0, 8'hA5);
    @(negedge clk);
    check_idle(0);

    // All requesters valid: 0,1,2,3,0 back to back
    do_reset();
    req_data = {d[3], d[2], d[1], d[0]};
    req_valid = 4'b1111;
    #1 check("ready_all_first", req_ready, 4'b0001);
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      if (g == 4) req_valid = '0;
      check_frame(order[g], d[order[g]]);
      if (g < 4) check("ready_rr", req_ready, nxt_ready[g]);
    end
    @(negedge clk);
    check_idle(0);

    // Grant 2, then 1101 -> 3, 0, 2
    req_valid = 4'b0100;
    #1 check("ready_r2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1101;
    check_frame(2, d[2]);
    check("ready_after2", req_ready, 4'b1000);
    @(negedge clk);
    check_frame(3, d[3]);
    check("ready_after3", req_ready, 4'b0001);
    @(negedge clk);
    check_frame(0, d[0]);
    check("ready_after0", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    check_frame(2, d[2]);
    @(negedge clk);
    check_idle(2);

    // Reset during a data bit aborts the frame
    do_reset();
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    check("abort_start", ser_out, 0);
    check("abort_grant", grant_id, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_bit", ser_out, (i % 2 == 1) ? 1 : 0);
    end
    rst = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("midrst_ser", ser_out, 1);
    check("midrst_active", ser_active, 0);
    check("midrst_done", done, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    req_data[7:0] = 8'hFF;
    #1 check("post_rst_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check_frame(0, 8'hFF);
    @(negedge clk);
    check_idle(0);

    // 0x07: parity bit 1 when enabled; length checked by frame + idle
    req_data[7:0] = 8'h07;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    check_frame(0, 8'h07);
    @(negedge clk);
    check_idle(0);

    // Data change after acceptance does not affect the frame
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    @(negedge clk);
    req_data[7:0] = 8'hC3;
    req_valid = '0;
    check_frame(0, 8'h3C);
    @(negedge clk);
    check_idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
